// File: rtl/throw_ctrl.sv
// -----------------------------------------------------------------------------
// throw_ctrl
//
// Local-player throw sequencer for the cat-and-dog game. When it is this
// board's turn, it charges throw power while the button is held and launches
// the projectile on release. It then integrates the trajectory once per video
// frame until the projectile lands on the ground or leaves the screen.
// throw_flag stays high for the whole flight. Its falling edge is what the
// turn manager counts to advance the turn.
//
// Parameters:
//   PLAYER        0 = cat (throws rightward), 1 = dog (throws leftward)
//   START_X/Y     launch position in pixels
//   GROUND_Y      y at which the projectile has landed
//   TARGET_X_MIN  lowest landing x counted as a hit (inclusive)
//   TARGET_X_MAX  highest landing x counted as a hit (inclusive)
//   SCREEN_W      screen width in pixels
//   GRAVITY       vy increment per frame tick
//   MAX_POWER     power saturation value
//
// Ports:
//   clk60MHz    in   system clock
//   rst         in   synchronous active-high reset
//   turn        in   [2:0] current turn number from the turn manager
//   btn         in   throw button level, already synchronised
//   frame_tick  in   one-cycle pulse per video frame
//   wind        in   [3:0] signed wind, -8..7
//   throw_flag  out  high while the projectile is in flight
//   proj_x      out  [11:0] signed projectile x
//   proj_y      out  [11:0] signed projectile y
//   power       out  [3:0] current or last charge power
//   hit         out  one-cycle pulse on a landing inside the target window
//
// Build option:
//   THROW_WIND_EN  when defined, the launch adds the signed wind to vx.
//                  Otherwise the wind port is accepted but ignored.
// -----------------------------------------------------------------------------
module throw_ctrl #(
  parameter int PLAYER       = 0,
  parameter int START_X      = 100,
  parameter int START_Y      = 400,
  parameter int GROUND_Y     = 400,
  parameter int TARGET_X_MIN = 600,
  parameter int TARGET_X_MAX = 680,
  parameter int SCREEN_W     = 800,
  parameter int GRAVITY      = 1,
  parameter int MAX_POWER    = 15
) (
  input  logic               clk60MHz,
  input  logic               rst,
  input  logic [2:0]         turn,
  input  logic               btn,
  input  logic               frame_tick,
  input  logic [3:0]         wind,
  output logic               throw_flag,
  output logic signed [11:0] proj_x,
  output logic signed [11:0] proj_y,
  output logic [3:0]         power,
  output logic               hit
);

  // Parameters are resized once here, so that every datapath compare and add
  // below works on matching signed widths.
  localparam logic signed [11:0] START_X_S    = 12'(START_X);
  localparam logic signed [11:0] START_Y_S    = 12'(START_Y);
  localparam logic signed [11:0] GROUND_Y_S   = 12'(GROUND_Y);
  localparam logic signed [11:0] TARGET_MIN_S = 12'(TARGET_X_MIN);
  localparam logic signed [11:0] TARGET_MAX_S = 12'(TARGET_X_MAX);
  localparam logic signed [11:0] SCREEN_MAX_S = 12'(SCREEN_W - 1);
  localparam logic signed [7:0]  GRAVITY_S    = 8'(GRAVITY);
  localparam logic [3:0]         MAX_POWER_U  = 4'(MAX_POWER);
  localparam logic               IS_DOG       = (PLAYER != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FLIGHT = 2'd2,
    LAND   = 2'd3
  } state_t;

  state_t state, state_next;

  logic                btn_prev;
  logic [2:0]          last_turn, last_turn_next;
  logic [3:0]          power_next;
  logic signed [11:0]  pos_x_next, pos_y_next;
  logic signed [7:0]   vel_x, vel_x_next;
  logic signed [7:0]   vel_y, vel_y_next;
  logic                hit_next;

  logic                my_turn;
  logic                btn_rise;
  logic                btn_fall;
  logic signed [7:0]   power_ext;
  logic signed [7:0]   dir_power;
  logic signed [7:0]   launch_vx;
  logic signed [11:0]  flight_x;
  logic signed [11:0]  flight_y;
  logic                off_screen;
  logic                in_target;

  // Turn ownership: the low bit of the turn number alternates between the
  // cat (odd turns) and the dog (even turns).
  assign my_turn  = turn[0] ^ IS_DOG;
  assign btn_rise = !btn_prev && btn;
  assign btn_fall = btn_prev && !btn;

  // The launch speed is the charged power. The dog throws towards
  // decreasing x, so it starts with a negative horizontal velocity.
  assign power_ext = $signed({4'b0000, power});
  assign dir_power = IS_DOG ? -power_ext : power_ext;

`ifdef THROW_WIND_EN
  assign launch_vx = dir_power + $signed({{4{wind[3]}}, wind});
`else
  logic wind_unused;
  assign wind_unused = ^wind;
  assign launch_vx   = dir_power;
`endif

  // Candidate position for the next frame. Velocities are sign-extended to
  // the 12-bit position width before they are added.
  assign flight_x = proj_x + $signed({{4{vel_x[7]}}, vel_x});
  assign flight_y = proj_y + $signed({{4{vel_y[7]}}, vel_y});

  assign off_screen = flight_x[11] || (flight_x > SCREEN_MAX_S);
  assign in_target  = (flight_x >= TARGET_MIN_S) && (flight_x <= TARGET_MAX_S);

  // Next-state and datapath logic. Each register holds its value unless a
  // state explicitly updates it.
  always_comb begin
    state_next     = state;
    power_next     = power;
    pos_x_next     = proj_x;
    pos_y_next     = proj_y;
    vel_x_next     = vel_x;
    vel_y_next     = vel_y;
    last_turn_next = last_turn;
    hit_next       = 1'b0;

    case (state)
      IDLE: begin
        // last_turn blocks a second launch during the few cycles before the
        // turn manager advances turn after a landing.
        if (my_turn && (turn != last_turn) && btn_rise) begin
          state_next = CHARGE;
          power_next = 4'd0;
        end
      end

      CHARGE: begin
        // A release takes priority over a tick in the same cycle, so the
        // launch uses the power that was visible before that tick.
        if (btn_fall) begin
          state_next     = FLIGHT;
          pos_x_next     = START_X_S;
          pos_y_next     = START_Y_S;
          vel_x_next     = launch_vx;
          vel_y_next     = -power_ext;
          last_turn_next = turn;
        end else if (frame_tick && (power < MAX_POWER_U)) begin
          power_next = power + 4'd1;
        end
      end

      FLIGHT: begin
        if (frame_tick) begin
          pos_x_next = flight_x;
          pos_y_next = flight_y;
          vel_y_next = vel_y + GRAVITY_S;
          // A ground contact is checked before the screen edges. A hit is
          // possible only for a ground landing.
          if (flight_y >= GROUND_Y_S) begin
            pos_y_next = GROUND_Y_S;
            state_next = LAND;
            hit_next   = in_target;
          end else if (off_screen) begin
            state_next = LAND;
          end
        end
      end

      LAND: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers. throw_flag and hit are registered from
  // the next state, so they change on the same edge as the state.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state      <= IDLE;
      btn_prev   <= 1'b0;
      last_turn  <= 3'b000;
      power      <= 4'd0;
      proj_x     <= START_X_S;
      proj_y     <= START_Y_S;
      vel_x      <= 8'sd0;
      vel_y      <= 8'sd0;
      throw_flag <= 1'b0;
      hit        <= 1'b0;
    end else begin
      state      <= state_next;
      btn_prev   <= btn;
      last_turn  <= last_turn_next;
      power      <= power_next;
      proj_x     <= pos_x_next;
      proj_y     <= pos_y_next;
      vel_x      <= vel_x_next;
      vel_y      <= vel_y_next;
      throw_flag <= (state_next == FLIGHT);
      hit        <= hit_next;
    end
  end

endmodule

// File: tb/tb_throw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_throw_ctrl
//
// Directed bench for throw_ctrl. It uses two instances:
//   - u_cat: PLAYER 0, target window 150..160
//   - u_dog: PLAYER 1, default parameters
// The instances share the clock, reset, turn, frame_tick and wind, and each
// has its own button. Inputs are driven and outputs are sampled on the
// falling clock edge. The expected wind step follows THROW_WIND_EN.
// -----------------------------------------------------------------------------
module tb_throw_ctrl;

  logic               clk60MHz;
  logic               rst;
  logic [2:0]         turn;
  logic               btn_cat;
  logic               btn_dog;
  logic               frame_tick;
  logic [3:0]         wind;

  logic               cat_flag;
  logic signed [11:0] cat_x;
  logic signed [11:0] cat_y;
  logic [3:0]         cat_power;
  logic               cat_hit;

  logic               dog_flag;
  logic signed [11:0] dog_x;
  logic signed [11:0] dog_y;
  logic [3:0]         dog_power;
  logic               dog_hit;

  int n_asserts;
  int n_fail;
  int wind_step;

  throw_ctrl #(
    .PLAYER      (0),
    .TARGET_X_MIN(150),
    .TARGET_X_MAX(160)
  ) u_cat (
    .clk60MHz  (clk60MHz),
    .rst       (rst),
    .turn      (turn),
    .btn       (btn_cat),
    .frame_tick(frame_tick),
    .wind      (wind),
    .throw_flag(cat_flag),
    .proj_x    (cat_x),
    .proj_y    (cat_y),
    .power     (cat_power),
    .hit       (cat_hit)
  );

  throw_ctrl #(
    .PLAYER(1)
  ) u_dog (
    .clk60MHz  (clk60MHz),
    .rst       (rst),
    .turn      (turn),
    .btn       (btn_dog),
    .frame_tick(frame_tick),
    .wind      (wind),
    .throw_flag(dog_flag),
    .proj_x    (dog_x),
    .proj_y    (dog_y),
    .power     (dog_power),
    .hit       (dog_hit)
  );

  initial clk60MHz = 1'b0;
  always #5 clk60MHz = ~clk60MHz;

  // Compares one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Holds frame_tick at the given level for a number of cycles, then drops it.
  task automatic applyStimulus(input logic tick, input int cycles);
    frame_tick = tick;
    repeat (cycles) @(negedge clk60MHz);
    frame_tick = 1'b0;
  endtask

  // Issues n frame ticks, each followed by one quiet cycle.
  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, 1);
    end
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
`ifdef THROW_WIND_EN
    wind_step  = 3;
`else
    wind_step  = 5;
`endif
    rst        = 1'b1;
    turn       = 3'd0;
    btn_cat    = 1'b0;
    btn_dog    = 1'b0;
    frame_tick = 1'b0;
    wind       = 4'd0;
    @(negedge clk60MHz);
    applyStimulus(1'b0, 2);

    // Reset state
    checkOutput("rst_flag",  {31'd0, cat_flag}, 32'd0);
    checkOutput("rst_hit",   {31'd0, cat_hit}, 32'd0);
    checkOutput("rst_power", {28'd0, cat_power}, 32'd0);
    checkOutput("rst_x",     {20'd0, cat_x}, 32'd100);
    checkOutput("rst_y",     {20'd0, cat_y}, 32'd400);
    rst = 1'b0;
    applyStimulus(1'b0, 1);

    // Cat hit trajectory: charge for 5 ticks, release, land at x=155
    turn    = 3'd1;
    btn_cat = 1'b1;
    applyStimulus(1'b0, 1);
    frameTicks(5);
    checkOutput("cat_charge_power", {28'd0, cat_power}, 32'd5);
    checkOutput("cat_charge_flag",  {31'd0, cat_flag}, 32'd0);
    btn_cat = 1'b0;
    checkOutput("cat_release_cycle_flag", {31'd0, cat_flag}, 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("cat_launch_flag", {31'd0, cat_flag}, 32'd1);
    checkOutput("cat_launch_x",    {20'd0, cat_x}, 32'd100);
    checkOutput("cat_launch_y",    {20'd0, cat_y}, 32'd400);
    frameTicks(10);
    checkOutput("cat_t10_x",    {20'd0, cat_x}, 32'd150);
    checkOutput("cat_t10_y",    {20'd0, cat_y}, 32'd395);
    checkOutput("cat_t10_flag", {31'd0, cat_flag}, 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("cat_land_hit",  {31'd0, cat_hit}, 32'd1);
    checkOutput("cat_land_flag", {31'd0, cat_flag}, 32'd0);
    checkOutput("cat_land_x",    {20'd0, cat_x}, 32'd155);
    checkOutput("cat_land_y",    {20'd0, cat_y}, 32'd400);
    applyStimulus(1'b0, 1);
    checkOutput("cat_hit_one_cycle", {31'd0, cat_hit}, 32'd0);

    // Relaunch guard: same turn, press ignored
    btn_cat = 1'b1;
    applyStimulus(1'b0, 1);
    frameTicks(2);
    btn_cat = 1'b0;
    applyStimulus(1'b0, 2);
    checkOutput("guard_flag",  {31'd0, cat_flag}, 32'd0);
    checkOutput("guard_power", {28'd0, cat_power}, 32'd5);

    // New turn 3: press accepted; launch with wind -2 at power 5
    turn    = 3'd3;
    wind    = 4'b1110;
    btn_cat = 1'b1;
    applyStimulus(1'b0, 1);
    checkOutput("turn3_accept_power", {28'd0, cat_power}, 32'd0);
    frameTicks(5);
    btn_cat = 1'b0;
    applyStimulus(1'b0, 1);
    checkOutput("wind_launch_flag", {31'd0, cat_flag}, 32'd1);
    frameTicks(1);
    checkOutput("wind_t1_x", {20'd0, cat_x}, 32'(100 + wind_step));
    checkOutput("wind_t1_y", {20'd0, cat_y}, 32'd395);
    frameTicks(1);
    checkOutput("wind_t2_x", {20'd0, cat_x}, 32'(100 + 2 * wind_step));
    checkOutput("wind_t2_y", {20'd0, cat_y}, 32'd391);

    // Reset mid-flight
    rst = 1'b1;
    applyStimulus(1'b0, 1);
    checkOutput("midrst_flag",  {31'd0, cat_flag}, 32'd0);
    checkOutput("midrst_x",     {20'd0, cat_x}, 32'd100);
    checkOutput("midrst_y",     {20'd0, cat_y}, 32'd400);
    checkOutput("midrst_hit",   {31'd0, cat_hit}, 32'd0);
    checkOutput("midrst_power", {28'd0, cat_power}, 32'd0);
    rst  = 1'b0;
    wind = 4'd0;
    frameTicks(2);
    checkOutput("postrst_flag", {31'd0, cat_flag}, 32'd0);
    checkOutput("postrst_hit",  {31'd0, cat_hit}, 32'd0);

    // Wrong turn for the cat: turn 2 belongs to the dog
    turn    = 3'd2;
    btn_cat = 1'b1;
    applyStimulus(1'b0, 1);
    frameTicks(3);
    btn_cat = 1'b0;
    applyStimulus(1'b0, 2);
    checkOutput("wrongturn_flag",  {31'd0, cat_flag}, 32'd0);
    checkOutput("wrongturn_power", {28'd0, cat_power}, 32'd0);

    // Dog: power saturation and leftward flight
    btn_dog = 1'b1;
    applyStimulus(1'b0, 1);
    frameTicks(40);
    checkOutput("dog_sat_power", {28'd0, dog_power}, 32'd15);
    btn_dog = 1'b0;
    applyStimulus(1'b0, 1);
    checkOutput("dog_launch_flag", {31'd0, dog_flag}, 32'd1);
    checkOutput("dog_launch_x",    {20'd0, dog_x}, 32'd100);
    frameTicks(1);
    checkOutput("dog_t1_x", {20'd0, dog_x}, 32'd85);
    checkOutput("dog_t1_y", {20'd0, dog_y}, 32'd385);
    frameTicks(5);
    checkOutput("dog_t6_x",    {20'd0, dog_x}, 32'd10);
    checkOutput("dog_t6_y",    {20'd0, dog_y}, 32'd325);
    checkOutput("dog_t6_flag", {31'd0, dog_flag}, 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("dog_offscreen_flag", {31'd0, dog_flag}, 32'd0);
    checkOutput("dog_offscreen_hit",  {31'd0, dog_hit}, 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("dog_after_land_hit", {31'd0, dog_hit}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/throw_ctrl.md
# throw_ctrl

- Local-player throw sequencer for the cat-and-dog game.
- On this board's turn, it charges throw power while the throw button is held, launches on release, and integrates the projectile trajectory once per frame tick.
- It holds `throw_flag` high for the whole flight and drops it on landing; that falling edge is what the turn manager counts to advance the turn.
- It sits between the input/mouse logic, the projectile drawing path and the turn manager.

## Interface
Parameters:
- `PLAYER`, 0: 0 = cat (left, throws rightward), 1 = dog (right, throws leftward)
- `START_X`, 100: launch x position in pixels
- `START_Y`, 400: launch y position in pixels
- `GROUND_Y`, 400: y position at which the projectile has landed
- `TARGET_X_MIN`, 600: lowest landing x that counts as a hit (inclusive)
- `TARGET_X_MAX`, 680: highest landing x that counts as a hit (inclusive)
- `SCREEN_W`, 800: screen width in pixels
- `GRAVITY`, 1: vy increment per frame tick
- `MAX_POWER`, 15: power saturation value

Ports:
- `clk60MHz` input 1: system clock.
- `rst` input 1: reset; synchronous, active-high, one clock domain.
- `turn` input 3: current turn number, from the turn manager.
- `btn` input 1: throw button, level, already synchronised.
- `frame_tick` input 1: one-cycle pulse per video frame.
- `wind` input 4: signed wind, −8..7; used only with `WIND_EN`.
- `throw_flag` output 1: high while the projectile is in flight.
- `proj_x` output 12: signed projectile x.
- `proj_y` output 12: signed projectile y.
- `power` output 4: current or last charge power.
- `hit` output 1: one-cycle pulse when a landing falls inside the target window.

## Operation
- **Turn ownership:** it is my turn when `turn[0] ^ PLAYER == 1`. Turn 001 belongs to the cat, turn 002 to the dog.
- **Turn latch:** `last_turn` holds the turn value in which the last throw was launched; reset value 3'b000.
- **Button edges:** `btn_prev` is a register. Rise = `!btn_prev & btn`; fall = `btn_prev & !btn`.
- **IDLE:**
  - Exit condition: my turn, `turn != last_turn`, and a button rise.
  - Action: go to CHARGE and set `power=0`.
  - All other events are ignored, including a rise while it is not my turn.
- **CHARGE:**
  - Each `frame_tick`: `power = min(power+1, MAX_POWER)`.
  - On a button fall: go to FLIGHT and launch.
    - Position: x=START_X, y=START_Y.
    - Velocity: vx = +power (PLAYER 0) or −power (PLAYER 1); vy = −power.
    - Latch `last_turn=turn`.
  - A tick and a fall in the same cycle: the fall wins and `power` is not incremented.
- **FLIGHT:**
  - Each `frame_tick`:
    - x += vx, y += vy, then vy += GRAVITY.
    - If the new y ≥ GROUND_Y: clamp y=GROUND_Y and go to LAND.
    - Else if the new x < 0 or x > SCREEN_W−1: go to LAND with no hit.
  - `btn` is ignored.
- **LAND:**
  - Lasts one cycle, then IDLE.
  - `hit`=1 in this cycle if the landing was on the ground and TARGET_X_MIN ≤ x ≤ TARGET_X_MAX.
- **Arithmetic:** 12-bit signed positions and 8-bit signed velocities, sign-extended before adding. No overflow is possible within the parameter ranges.
- **Outputs:** `throw_flag` is registered, = (state==FLIGHT). Power 0 is legal: the projectile launches, vy starts at 0, and it lands on the next tick at x=START_X.

## Timing
- Reset values: `throw_flag`=0, `hit`=0, `power`=0, `proj_x`=START_X, `proj_y`=START_Y, state IDLE, `btn_prev`=0, `last_turn`=0.
- Release to `throw_flag` high: the first cycle with `btn`=0 is cycle N; `throw_flag`=1 from N+1.
- Position outputs update on the cycle after `frame_tick`.
- `throw_flag` falls on the same edge that enters LAND. `hit` is high for exactly that cycle.
- The turn manager sees the fall and advances `turn` 2 cycles later. The `last_turn` guard blocks any relaunch in the gap.
- `rst` mid-flight or mid-charge: everything returns to reset values on the next edge. No landing, no hit.

## Configuration
- `THROW_WIND_EN` defined: the launch adds sign-extended `wind` to vx, i.e. vx = ±power + wind.
- Not defined: the `wind` port is present but ignored, and vx = ±power.

## Test plan
- **Cat hit trajectory:** PLAYER=0, turn=001, TARGET 150..160. Press btn, 5 ticks, release → power=5, `throw_flag`=1 one cycle after release. After 11 ticks: y=400, x=155, `hit`=1 for one cycle, `throw_flag`=0.
- **Wrong turn:** PLAYER=0, turn=002, press/release → state stays IDLE, `throw_flag` stays 0, `power` stays 0.
- **Power saturation and dog direction:** PLAYER=1, turn=002, hold for 40 ticks → power=15. Release → x decreases by 15 on the first tick.
- **Relaunch guard:** after landing, press again with turn still 001 → ignored. Change turn to 003 → the press is accepted.
- **Reset mid-flight:** reset during FLIGHT → `throw_flag`=0, `proj_x`=100, `proj_y`=400, no `hit` pulse.
- **Wind:** with `THROW_WIND_EN`, wind=−2, power=5 → x advances 3 per tick. Without the macro → x advances 5 per tick.
